// File: rtl/cia_pkg.sv
// Shared definitions for the CIA serial-port peer and anything that talks to it.
// Holds the peer FSM encoding, link-direction constants and CIA control-bit indices.
package cia_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TX_LOW  = 2'd1,
        TX_HIGH = 2'd2
    } sp_state_t;

    localparam logic MODE_TX = 1'b0;
    localparam logic MODE_RX = 1'b1;

    // CRA bit selecting SP direction on the CIA (1 = CIA drives SP/CNT)
    localparam int CRA_SPMODE = 6;

endpackage

// File: rtl/cia_sp_sync.sv
// Two-flop synchronizer for CNT and SP, plus a rising-edge detector on CNT
// that only looks at CNT on phi2 ticks, matching the CIA's own sampling.
module cia_sp_sync
    import cia_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_phi2,
    input  logic i_cnt,
    input  logic i_sp,
    output logic o_cnt_rise,
    output logic o_sp
);

    logic r_cnt_s1, r_cnt_s2, r_cnt_prev;
    logic r_sp_s1, r_sp_s2;

    // Idle level of both lines is high, so resetting to 1 avoids a phantom edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt_s1   <= 1'b1;
            r_cnt_s2   <= 1'b1;
            r_cnt_prev <= 1'b1;
            r_sp_s1    <= 1'b1;
            r_sp_s2    <= 1'b1;
        end else begin
            r_cnt_s1 <= i_cnt;
            r_cnt_s2 <= r_cnt_s1;
            r_sp_s1  <= i_sp;
            r_sp_s2  <= r_sp_s1;
            if (i_phi2)
                r_cnt_prev <= r_cnt_s2;
        end
    end

    assign o_cnt_rise = i_phi2 & r_cnt_s2 & ~r_cnt_prev;
    assign o_sp       = r_sp_s2;

endmodule

// File: rtl/cia_sp_peer.sv
// Link partner on the CIA SP/CNT wires: clock master when transmitting,
// CNT-edge sampler when receiving, with overrun flagging and partial-byte timeout.
module cia_sp_peer
    import cia_pkg::*;
#(
    parameter int CNT_HALF   = 4,
    parameter int RX_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       phi2,
    input  logic       mode,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_overrun,
    input  logic       rx_ack,
    input  logic       sp_in,
    input  logic       cnt_in,
    output logic       sp_out,
    output logic       cnt_out,
    output logic       busy
);

    localparam int PW = $clog2(CNT_HALF + 1);
    localparam int TW = $clog2(RX_TIMEOUT + 1);

    sp_state_t     r_state, w_state_nxt;
    logic [PW-1:0] r_phase;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_sr;
    logic          r_sp_out, r_cnt_out;
    logic          r_run;

    logic [7:0]    r_rx_sr;
    logic [2:0]    r_rx_bit;
    logic [TW-1:0] r_rx_to;
    logic          r_rx_pend;

    logic w_accept, w_phase_done, w_abort;
    logic w_cnt_rise, w_sp_s, w_rx_edge, w_rx_done, w_rx_tmo;

    cia_sp_sync u_sync (
        .clk        (clk),
        .reset      (reset),
        .i_phi2     (phi2),
        .i_cnt      (cnt_in),
        .i_sp       (sp_in),
        .o_cnt_rise (w_cnt_rise),
        .o_sp       (w_sp_s)
    );

    assign w_accept     = tx_valid & tx_ready;
    assign w_phase_done = phi2 && (r_phase == PW'(CNT_HALF - 1));
    assign w_abort      = (mode == MODE_RX) && (r_state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = TX_LOW;
            TX_LOW:  if (w_abort) w_state_nxt = IDLE;
                     else if (w_phase_done) w_state_nxt = TX_HIGH;
            TX_HIGH: if (w_abort) w_state_nxt = IDLE;
                     else if (w_phase_done) w_state_nxt = (r_tx_bit == 3'd7) ? IDLE : TX_LOW;
            default: w_state_nxt = IDLE;
        endcase
    end

    // r_run keeps tx_ready low while reset is held, even though the FSM sits in IDLE
    always_comb begin
        tx_ready = r_run && (r_state == IDLE) && (mode == MODE_TX);
        busy     = (r_state != IDLE) || (r_rx_bit != 3'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run     <= 1'b0;
            r_phase   <= '0;
            r_tx_bit  <= 3'd0;
            r_tx_sr   <= 8'h00;
            r_sp_out  <= 1'b1;
            r_cnt_out <= 1'b1;
        end else begin
            r_run <= 1'b1;
            if (w_abort) begin
                r_phase   <= '0;
                r_tx_bit  <= 3'd0;
                r_sp_out  <= 1'b1;
                r_cnt_out <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: if (w_accept) begin
                        r_tx_sr   <= tx_data;
                        r_tx_bit  <= 3'd0;
                        r_phase   <= '0;
                        r_sp_out  <= tx_data[7];
                        r_cnt_out <= 1'b0;
                    end
                    TX_LOW: if (phi2) begin
                        if (w_phase_done) begin
                            r_cnt_out <= 1'b1;
                            r_phase   <= '0;
                        end else begin
                            r_phase <= r_phase + PW'(1);
                        end
                    end
                    TX_HIGH: if (phi2) begin
                        if (w_phase_done) begin
                            r_phase <= '0;
                            if (r_tx_bit == 3'd7) begin
                                r_sp_out <= 1'b1;
                            end else begin
                                r_tx_sr   <= {r_tx_sr[6:0], 1'b0};
                                r_sp_out  <= r_tx_sr[6];
                                r_cnt_out <= 1'b0;
                                r_tx_bit  <= r_tx_bit + 3'd1;
                            end
                        end else begin
                            r_phase <= r_phase + PW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sp_out  = r_sp_out;
    assign cnt_out = r_cnt_out;

    // Receive side only listens in RX mode so our own CNT loopback is ignored
    assign w_rx_edge = w_cnt_rise && (mode == MODE_RX);
    assign w_rx_done = w_rx_edge && (r_rx_bit == 3'd7);
    assign w_rx_tmo  = phi2 && (r_rx_bit != 3'd0) && (r_rx_to == TW'(RX_TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_sr    <= 8'h00;
            r_rx_bit   <= 3'd0;
            r_rx_to    <= '0;
            r_rx_pend  <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_valid <= w_rx_done;
            if (mode == MODE_TX) begin
                r_rx_bit <= 3'd0;
                r_rx_to  <= '0;
            end else if (w_rx_edge) begin
                r_rx_sr  <= {r_rx_sr[6:0], w_sp_s};
                r_rx_bit <= r_rx_bit + 3'd1;
                r_rx_to  <= '0;
                if (w_rx_done)
                    rx_data <= {r_rx_sr[6:0], w_sp_s};
            end else if (r_rx_bit == 3'd0) begin
                r_rx_to <= '0;
            end else if (w_rx_tmo) begin
                r_rx_bit <= 3'd0;
                r_rx_to  <= '0;
            end else if (phi2) begin
                r_rx_to <= r_rx_to + TW'(1);
            end

            // A completion coinciding with rx_ack wins: byte pending, overrun clear
            if (w_rx_done) begin
                r_rx_pend  <= 1'b1;
                rx_overrun <= (r_rx_pend | rx_overrun) & ~rx_ack;
            end else if (rx_ack) begin
                r_rx_pend  <= 1'b0;
                rx_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cia_sp_peer.sv
// Directed bench for cia_sp_peer: the bench plays the CIA on the wires and
// scoreboards every transmitted and received byte against hand-computed values.
module tb_cia_sp_peer;
    import cia_pkg::*;

    localparam int CNT_HALF   = 4;
    localparam int RX_TIMEOUT = 1024;
    localparam int H          = 3;

    logic       clk = 1'b0, reset = 1'b1, phi2 = 1'b0, mode = 1'b0;
    logic       tx_valid = 1'b0, rx_ack = 1'b0, sp_in = 1'b1, cnt_in = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, rx_valid, rx_overrun, sp_out, cnt_out, busy;
    logic [7:0] rx_data;

    typedef struct { logic [7:0] data; logic ovr; } rx_exp_t;
    rx_exp_t    rx_q[$];
    logic [7:0] tx_q[$];

    int n_checks = 0, n_fail = 0;
    int tx_rises = 0, tx_n = 0, phc = 0;
    logic       prev_cnt = 1'b1;
    logic [7:0] tx_bits = 8'h00;
    logic [7:0] cra = 8'h00;

    cia_sp_peer #(.CNT_HALF(CNT_HALF), .RX_TIMEOUT(RX_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .phi2(phi2), .mode(mode),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_overrun(rx_overrun), .rx_ack(rx_ack),
        .sp_in(sp_in), .cnt_in(cnt_in), .sp_out(sp_out), .cnt_out(cnt_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // phi2 strobe every 4th clk, changed just after posedge so negedge sees it stable
    initial forever begin
        @(posedge clk);
        #2;
        phc++;
        phi2 = (phc % 4 == 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // RX scoreboard
    always @(negedge clk) begin
        if (!reset && rx_valid) begin
            if (rx_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx_unexpected: got data 0x%0h, no byte expected", rx_data);
            end else begin
                rx_exp_t e;
                e = rx_q.pop_front();
                check("rx_data", {24'h0, rx_data}, {24'h0, e.data});
                check("rx_overrun", {31'h0, rx_overrun}, {31'h0, e.ovr});
            end
        end
    end

    // TX monitor: acts as a CIA in input mode, sampling SP on CNT rising edges
    always @(negedge clk) begin
        if (reset || !busy) begin
            tx_n = 0;
        end else if (cnt_out && !prev_cnt) begin
            tx_bits = {tx_bits[6:0], sp_out};
            tx_n++;
            tx_rises++;
            if (tx_n == 8) begin
                tx_n = 0;
                if (tx_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got byte 0x%0h, none expected", tx_bits);
                end else begin
                    check("tx_byte", {24'h0, tx_bits}, {24'h0, tx_q.pop_front()});
                end
            end
        end
        prev_cnt = cnt_out;
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(negedge clk); while (!phi2);
        end
    endtask

    task automatic cia_bit(input logic b);
        cnt_in = 1'b0;
        sp_in  = b;
        wait_ticks(H);
        cnt_in = 1'b1;
        wait_ticks(H);
    endtask

    task automatic cia_byte(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) cia_bit(d[i]);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit expect_it);
        int g;
        g = 0;
        while (!tx_ready && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (!tx_ready) begin
            fail_now("tx_ready_wait");
        end else begin
            tx_data  = d;
            tx_valid = 1'b1;
            if (expect_it) tx_q.push_back(d);
            @(posedge clk);
            @(negedge clk);
            tx_valid = 1'b0;
        end
    endtask

    task automatic wait_rises(input int target);
        int g;
        g = 0;
        while (tx_rises < target && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (tx_rises < target) fail_now("cnt_rise_wait");
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (busy && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (busy) fail_now("idle_wait");
    endtask

    task automatic ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    initial begin
        int base, bt, g;

        @(negedge clk);
        check("rst_sp_out", {31'h0, sp_out}, 32'h1);
        check("rst_cnt_out", {31'h0, cnt_out}, 32'h1);
        check("rst_tx_ready", {31'h0, tx_ready}, 32'h0);
        check("rst_rx_data", {24'h0, rx_data}, 32'h0);
        check("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
        check("rst_rx_overrun", {31'h0, rx_overrun}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("tx_ready_after_rst", {31'h0, tx_ready}, 32'h1);

        // Transmit 0xA5 into a CIA with CRA=0x00
        cra  = 8'h00;
        mode = cra[CRA_SPMODE];
        base = tx_rises;
        send_byte(8'hA5, 1'b1);
        bt = 0;
        g  = 0;
        while (busy && g < 5000) begin
            if (phi2) bt++;
            @(negedge clk);
            g++;
        end
        check("tx_busy_ticks", bt, 16 * CNT_HALF);
        check("tx_rise_count", tx_rises - base, 8);

        // CIA with CRA=0x51 shifts out 0x3C
        cra  = 8'h51;
        mode = cra[CRA_SPMODE];
        wait_ticks(2);
        rx_q.push_back('{data: 8'h3C, ovr: 1'b0});
        cia_byte(8'h3C);
        wait_ticks(4);
        ack();

        // Two bytes without acknowledge: second overruns
        rx_q.push_back('{data: 8'h01, ovr: 1'b0});
        rx_q.push_back('{data: 8'hFE, ovr: 1'b1});
        cia_byte(8'h01);
        cia_byte(8'hFE);
        wait_ticks(4);
        ack();
        check("ovr_after_ack", {31'h0, rx_overrun}, 32'h0);

        // Partial byte then stall past the timeout, then a clean 0x81
        cia_bit(1'b1);
        cia_bit(1'b0);
        cia_bit(1'b1);
        check("rx_partial_busy", {31'h0, busy}, 32'h1);
        wait_ticks(RX_TIMEOUT + 1);
        check("rx_timeout_busy", {31'h0, busy}, 32'h0);
        rx_q.push_back('{data: 8'h81, ovr: 1'b0});
        cia_byte(8'h81);
        wait_ticks(4);
        ack();

        // Abort a transmit of 0xFF by flipping to receive after 3 CNT rises
        cra  = 8'h00;
        mode = cra[CRA_SPMODE];
        wait_ticks(2);
        base = tx_rises;
        send_byte(8'hFF, 1'b0);
        wait_rises(base + 3);
        mode = MODE_RX;
        @(posedge clk);
        #1;
        check("abort_cnt_out", {31'h0, cnt_out}, 32'h1);
        check("abort_sp_out", {31'h0, sp_out}, 32'h1);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_tx_ready", {31'h0, tx_ready}, 32'h0);
        wait_ticks(20);
        check("abort_tx_ready_hold", {31'h0, tx_ready}, 32'h0);
        mode = MODE_TX;
        wait_ticks(2);

        // Reset in the middle of bit 5 of 0x99 (SP and CNT both low there)
        base = tx_rises;
        send_byte(8'h99, 1'b0);
        wait_rises(base + 5);
        wait_ticks(CNT_HALF + 1);
        reset = 1'b1;
        #1;
        check("mid_rst_sp_out", {31'h0, sp_out}, 32'h1);
        check("mid_rst_cnt_out", {31'h0, cnt_out}, 32'h1);
        check("mid_rst_tx_ready", {31'h0, tx_ready}, 32'h0);
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_rx_data", {24'h0, rx_data}, 32'h0);
        check("mid_rst_rx_valid", {31'h0, rx_valid}, 32'h0);
        check("mid_rst_overrun", {31'h0, rx_overrun}, 32'h0);
        wait_ticks(2);
        reset = 1'b0;
        @(negedge clk);
        check("tx_ready_after_mid_rst", {31'h0, tx_ready}, 32'h1);
        send_byte(8'h42, 1'b1);
        wait_idle();
        wait_ticks(4);

        check("tx_queue_drained", tx_q.size(), 0);
        check("rx_queue_drained", rx_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
